jump_ctrl: RTL and testbench
============================

# jump_ctrl

Generates the two jump-request codes consumed by the next-PC unit. IF-stage requests come from a combinational predecode of the fetched word, and ID-stage requests come from a registered ID copy of the same word resolved against forwarded register values. It owns branch prediction: static predict-taken, or an optional 2-bit BHT. It issues corrective requests (`ID_BRANCH`, `ID_BRANCH_RESUME`, `ID_JR`, `ID_JALR`) together with an IF/ID flush.

## Interface
- `BHT_ENTRIES`, default 16, number of BHT counters (power of two); used only with `JUMP_CTRL_BHT_EN`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_ins`  in  32  instruction word in IF.
- `if_pc`  in  32  PC of `if_ins`.
- `stall`  in  1  hazard unit holds PC and IF/ID this cycle.
- `id_rs_val`  in  32  forwarded rs value for the ID instruction.
- `id_rt_val`  in  32  forwarded rt value for the ID instruction.
- `IFJumpOp`  out  2  encodings: 0 NONE, 1 IF_J, 2 IF_JAL, 3 IF_BRANCH.
- `IDJumpOp`  out  3  encodings: 0 NONE, 1 ID_JR, 2 ID_JALR, 3 ID_BRANCH, 4 ID_BRANCH_RESUME.
- `if_flush`  out  1  the IF/ID register loads a bubble at the next edge.
- `mispredict_cnt`  out  16  count of corrective branch redirects.

## Operation
- IF predecode (combinational) on `if_ins[31:26]`:
  - 000010 gives `IF_J`.
  - 000011 gives `IF_JAL`.
  - 000100 (beq) or 000101 (bne) gives `IF_BRANCH` if the prediction is taken, else NONE.
  - All other opcodes give NONE.
- ID register `{id_valid, id_ins, id_pc, id_pred}`:
  - Loads `{1, if_ins, if_pc, if_pred}` at each edge where `stall`=0.
  - `id_valid` loads 0 instead when `if_flush`=1.
  - Holds while `stall`=1.
- ID resolve (combinational). Applies only when `id_valid`=1 and `stall`=0; otherwise `IDJumpOp`=NONE.
  - Opcode 0 with funct 001000 gives `ID_JR`; funct 001001 gives `ID_JALR`.
  - beq/bne: `taken = (id_rs_val == id_rt_val) ^ is_bne`, compared at full 32 bits.
    - `taken` and not `id_pred` gives `ID_BRANCH`.
    - Not `taken` and `id_pred` gives `ID_BRANCH_RESUME`.
    - A correct prediction gives NONE.
- Redirect priority:
  - `if_flush = (IDJumpOp != 0)`.
  - `IFJumpOp` is forced to NONE whenever `IDJumpOp != 0`, `stall`=1, or `rst`=1.
  - Forcing NONE keeps the next-PC unit's saved branch address intact for a later resume.
- `mispredict_cnt`: +1 at each edge where `IDJumpOp` is `ID_BRANCH` or `ID_BRANCH_RESUME`. It wraps at 16'hFFFF to 0.
- One redirect per instruction: after a redirect edge the ID slot holds the flushed bubble.

## Timing
- IF predecode: 0-cycle latency, same cycle as fetch.
- ID resolve: one cycle after fetch, 0-cycle combinational from the ID register and the forwarded values.
- Stall with a mispredicted branch in ID:
  - `IDJumpOp` stays 0 for every stalled cycle.
  - The redirect fires exactly once, on the first cycle with `stall`=0.
  - The BHT is not updated while stalled.
- Reset (asynchronous; also applies mid-operation):
  - `id_valid`=0, `mispredict_cnt`=0, BHT counters = 2'b10.
  - `IFJumpOp`=0, `IDJumpOp`=0, `if_flush`=0 immediately while `rst`=1.
  - A pending redirect is dropped.

## Configuration
- Without `JUMP_CTRL_BHT_EN`: static prediction, `if_pred` = 1 for every beq/bne.
- With `JUMP_CTRL_BHT_EN`:
  - `BHT_ENTRIES` 2-bit saturating counters indexed by `pc[log2(BHT_ENTRIES)+1:2]`.
  - `if_pred` = counter[1] at index `if_pc`.
  - Update: at each edge where a valid, unstalled beq/bne is in ID, the counter at index `id_pc` increments if `taken`, else decrements, saturating at 0 and 3.
  - When the IF read and the ID update hit the same index in one cycle, IF sees the pre-update value.

## Test plan
- Static build: beq with rs=rt=7, fetched.
  - IF cycle: `IFJumpOp`=3.
  - Next cycle: `IDJumpOp`=0, `if_flush`=0, `mispredict_cnt`=0.
- Static build: bne with rs=rt=5.
  - IF cycle: `IFJumpOp`=3.
  - Next cycle: `IDJumpOp`=4, `if_flush`=1, `IFJumpOp`=0.
  - Following cycle: ID slot invalid, `mispredict_cnt`=1.
- `jr $31` (`if_ins`=32'h03E00008) in ID: `IDJumpOp`=1, `if_flush`=1. Likewise jalr gives 2. j (32'h08000010) in IF gives `IFJumpOp`=1.
- Mispredicted bne held in ID with `stall`=1 for 2 cycles:
  - `IDJumpOp`=0 both cycles.
  - 4 on the third cycle, 0 afterwards.
  - `mispredict_cnt` +1 only.
- `JUMP_CTRL_BHT_EN`: beq at PC 0x40 resolved not-taken twice.
  - Counter goes 10→01→00.
  - Third fetch: `IFJumpOp`=0, and the not-taken resolve gives `IDJumpOp`=0.
  - A later taken resolve gives `IDJumpOp`=3.
- `rst` pulsed mid-cycle with a mispredicted branch in ID: all outputs 0 asynchronously, `mispredict_cnt`=0. After release, the first fetched j gives `IFJumpOp`=1 and `IDJumpOp`=0.

Source files
------------

// File: rtl/jump_ctrl.sv
// Jump-request generation for the next-PC unit: IF predecode, ID resolve, branch prediction.
// Define JUMP_CTRL_BHT_EN to replace static predict-taken with a 2-bit BHT.
module jump_ctrl #(
    parameter int unsigned BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_ins,
    input  logic [31:0] if_pc,
    input  logic        stall,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    output logic [1:0]  IFJumpOp,
    output logic [2:0]  IDJumpOp,
    output logic        if_flush,
    output logic [15:0] mispredict_cnt
);

    typedef enum logic [1:0] {IF_NONE, IF_J, IF_JAL, IF_BRANCH} if_op_e;
    typedef enum logic [2:0] {ID_NONE, ID_JR, ID_JALR, ID_BRANCH, ID_BRANCH_RESUME} id_op_e;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    if_op_e      if_op;
    id_op_e      id_op;
    logic        if_pred;
    logic        if_is_branch;

    logic        id_valid;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic        id_pred;
    logic        id_is_branch;
    logic        id_taken;
    logic        id_branch_live;

    assign if_is_branch = (if_ins[31:26] == OP_BEQ) || (if_ins[31:26] == OP_BNE);
    assign id_is_branch = (id_ins[31:26] == OP_BEQ) || (id_ins[31:26] == OP_BNE);
    assign id_taken     = (id_rs_val == id_rt_val) ^ (id_ins[31:26] == OP_BNE);
    assign id_branch_live = id_valid && !stall && id_is_branch;

    always_comb begin
        id_op = ID_NONE;
        if (id_valid && !stall && !rst) begin
            if (id_ins[31:26] == OP_SPECIAL) begin
                if (id_ins[5:0] == FN_JR)
                    id_op = ID_JR;
                else if (id_ins[5:0] == FN_JALR)
                    id_op = ID_JALR;
            end else if (id_is_branch) begin
                if (id_taken && !id_pred)
                    id_op = ID_BRANCH;
                else if (!id_taken && id_pred)
                    id_op = ID_BRANCH_RESUME;
            end
        end
    end

    // An ID redirect, stall or reset suppresses IF so the saved branch address survives.
    always_comb begin
        if_op = IF_NONE;
        if (id_op == ID_NONE && !stall && !rst) begin
            case (if_ins[31:26])
                OP_J:           if_op = IF_J;
                OP_JAL:         if_op = IF_JAL;
                OP_BEQ, OP_BNE: if_op = if_pred ? IF_BRANCH : IF_NONE;
                default:        if_op = IF_NONE;
            endcase
        end
    end

    assign IFJumpOp = if_op;
    assign IDJumpOp = id_op;
    assign if_flush = (id_op != ID_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_ins   <= '0;
            id_pc    <= '0;
            id_pred  <= 1'b0;
        end else if (!stall) begin
            id_valid <= !if_flush;
            id_ins   <= if_ins;
            id_pc    <= if_pc;
            id_pred  <= if_pred;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mispredict_cnt <= '0;
        else if (id_op == ID_BRANCH || id_op == ID_BRANCH_RESUME)
            mispredict_cnt <= mispredict_cnt + 16'd1;
    end

`ifdef JUMP_CTRL_BHT_EN
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] id_idx;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign id_idx  = id_pc[IDX_W+1:2];
    // Combinational read of the array gives IF the pre-update value on an index clash.
    assign if_pred = bht[if_idx][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= 2'b10;
        end else if (id_branch_live) begin
            if (id_taken && bht[id_idx] != 2'b11)
                bht[id_idx] <= bht[id_idx] + 2'd1;
            else if (!id_taken && bht[id_idx] != 2'b00)
                bht[id_idx] <= bht[id_idx] - 2'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{if_ins[25:0], if_pc[31:IDX_W+2], if_pc[1:0],
                           id_ins[25:6], id_pc[31:IDX_W+2], id_pc[1:0]};
`else
    localparam int unsigned unused_bht_entries = BHT_ENTRIES;

    assign if_pred = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{if_ins[25:0], if_pc, id_ins[25:6], id_pc, id_branch_live};
`endif

endmodule

// File: tb/tb_jump_ctrl.sv
// Table-driven bench for jump_ctrl; BHT vectors are selected when JUMP_CTRL_BHT_EN is defined.
module tb_jump_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        stall;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [1:0]  IFJumpOp;
    logic [2:0]  IDJumpOp;
    logic        if_flush;
    logic [15:0] mispredict_cnt;

    jump_ctrl #(.BHT_ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .if_ins(if_ins), .if_pc(if_pc), .stall(stall),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .IFJumpOp(IFJumpOp), .IDJumpOp(IDJumpOp), .if_flush(if_flush),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] BEQ  = 32'h1022_0004;
    localparam logic [31:0] BNE  = 32'h1422_0004;
    localparam logic [31:0] JR   = 32'h03E0_0008;
    localparam logic [31:0] JALR = 32'h0020_F809;
    localparam logic [31:0] J    = 32'h0800_0010;
    localparam logic [31:0] JAL  = 32'h0C00_0020;
    localparam logic [31:0] ADDI = 32'h2001_0005;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        stall;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [1:0]  e_if;
        logic [2:0]  e_id;
        logic        e_fl;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic [31:0] ins, input logic [31:0] pc, input logic stl,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [1:0] e_if,
                       input logic [2:0] e_id, input logic e_fl, input logic [15:0] e_cnt);
        vec_t v;
        v.ins = ins; v.pc = pc; v.stall = stl; v.rs = rs; v.rt = rt;
        v.e_if = e_if; v.e_id = e_id; v.e_fl = e_fl; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_if, input logic [2:0] e_id,
                             input logic e_fl, input logic [15:0] e_cnt);
        check({tag, " IFJumpOp"}, {30'd0, IFJumpOp}, {30'd0, e_if});
        check({tag, " IDJumpOp"}, {29'd0, IDJumpOp}, {29'd0, e_id});
        check({tag, " if_flush"}, {31'd0, if_flush}, {31'd0, e_fl});
        check({tag, " mispredict_cnt"}, {16'd0, mispredict_cnt}, {16'd0, e_cnt});
    endtask

    initial begin
`ifdef JUMP_CTRL_BHT_EN
        // beq @0x40 with rs!=rt: counter 10 -> 01 -> 00, then a taken resolve
        add(BEQ, 32'h40, 0, 32'd1, 32'd2, 2'd3, 3'd0, 0, 16'd0);
        add(BEQ, 32'h40, 0, 32'd1, 32'd2, 2'd0, 3'd4, 1, 16'd0);
        add(BEQ, 32'h40, 0, 32'd1, 32'd2, 2'd0, 3'd0, 0, 16'd1);
        add(BEQ, 32'h40, 0, 32'd1, 32'd2, 2'd0, 3'd0, 0, 16'd1);
        add(BEQ, 32'h40, 0, 32'd3, 32'd3, 2'd0, 3'd3, 1, 16'd1);
        add(NOP, 32'h00, 0, 32'd3, 32'd3, 2'd0, 3'd0, 0, 16'd2);
        add(J,   32'h00, 0, 32'd0, 32'd0, 2'd1, 3'd0, 0, 16'd2);
`else
        add(BEQ,  32'h0, 0, 32'd7, 32'd7, 2'd3, 3'd0, 0, 16'd0);
        add(NOP,  32'h0, 0, 32'd7, 32'd7, 2'd0, 3'd0, 0, 16'd0);
        add(BNE,  32'h0, 0, 32'd5, 32'd5, 2'd3, 3'd0, 0, 16'd0);
        add(NOP,  32'h0, 0, 32'd5, 32'd5, 2'd0, 3'd4, 1, 16'd0);
        add(NOP,  32'h0, 0, 32'd0, 32'd0, 2'd0, 3'd0, 0, 16'd1);
        add(JR,   32'h0, 0, 32'd0, 32'd0, 2'd0, 3'd0, 0, 16'd1);
        add(J,    32'h0, 0, 32'd0, 32'd0, 2'd0, 3'd1, 1, 16'd1);
        add(J,    32'h0, 0, 32'd0, 32'd0, 2'd1, 3'd0, 0, 16'd1);
        add(JALR, 32'h0, 0, 32'd0, 32'd0, 2'd0, 3'd0, 0, 16'd1);
        add(JAL,  32'h0, 0, 32'd0, 32'd0, 2'd0, 3'd2, 1, 16'd1);
        add(JAL,  32'h0, 0, 32'd0, 32'd0, 2'd2, 3'd0, 0, 16'd1);
        // mispredicted bne held two cycles by stall
        add(BNE,  32'h0, 0, 32'd5, 32'd5, 2'd3, 3'd0, 0, 16'd1);
        add(J,    32'h0, 1, 32'd5, 32'd5, 2'd0, 3'd0, 0, 16'd1);
        add(J,    32'h0, 1, 32'd5, 32'd5, 2'd0, 3'd0, 0, 16'd1);
        add(NOP,  32'h0, 0, 32'd5, 32'd5, 2'd0, 3'd4, 1, 16'd1);
        // full-width compare: differs only in bit 31
        add(BEQ,  32'h0, 0, 32'h8000_0007, 32'd7, 2'd3, 3'd0, 0, 16'd2);
        add(NOP,  32'h0, 0, 32'h8000_0007, 32'd7, 2'd0, 3'd4, 1, 16'd2);
        add(BNE,  32'h0, 0, 32'd1, 32'd2, 2'd3, 3'd0, 0, 16'd3);
        add(ADDI, 32'h0, 0, 32'd1, 32'd2, 2'd0, 3'd0, 0, 16'd3);
        add(NOP,  32'h0, 0, 32'd1, 32'd2, 2'd0, 3'd0, 0, 16'd3);
`endif

        rst = 1'b1; if_ins = J; if_pc = '0; stall = 1'b0; id_rs_val = '0; id_rt_val = '0;
        #12;
        check_all("reset", 2'd0, 3'd0, 1'b0, 16'd0);
        if_ins = NOP;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            if_ins = vecs[i].ins; if_pc = vecs[i].pc; stall = vecs[i].stall;
            id_rs_val = vecs[i].rs; id_rt_val = vecs[i].rt;
            @(negedge clk);
            check_all($sformatf("v%0d", i), vecs[i].e_if, vecs[i].e_id, vecs[i].e_fl, vecs[i].e_cnt);
        end

        // asynchronous reset with a mispredicted bne sitting in ID
        @(posedge clk);
        #1;
        if_ins = BNE; if_pc = 32'h44; stall = 1'b0; id_rs_val = 32'd5; id_rt_val = 32'd5;
        @(posedge clk);
        #1;
        if_ins = NOP;
        check("pre-rst IDJumpOp", {29'd0, IDJumpOp}, 32'd4);
        #1 rst = 1'b1;
        #1;
        check_all("mid-rst", 2'd0, 3'd0, 1'b0, 16'd0);
        #1 rst = 1'b0;
        if_ins = J; if_pc = '0;
        @(negedge clk);
        check_all("post-rst", 2'd1, 3'd0, 1'b0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
